// File: rtl/ro_freq_counter_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
// Holds the FSM state encoding and the helpers that size the settle window and byte readout.
package ro_freq_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_COUNT  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int unsigned SYNC_STAGES_DFLT = 2;

   // Settle covers the synchronizer depth plus the edge-detect flop.
   function automatic int unsigned settle_len(input int unsigned sync_stages);
      return sync_stages + 1;
   endfunction

   localparam int unsigned SETTLE_LEN_DFLT = settle_len(SYNC_STAGES_DFLT);

   // Byte-select width; never narrower than one bit.
   function automatic int unsigned bsel_w(input int unsigned cnt_w);
      int unsigned nb;
      nb = (cnt_w + 7) / 8;
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/ro_freq_counter_sync_edge.sv
// Multi-flop synchronizer for one asynchronous oscillator input, followed by
// a rising-edge detector on the synchronized level.
module ro_sync_edge
   import ro_freq_counter_pkg::*;
#(
   parameter int unsigned STAGES = SYNC_STAGES_DFLT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise_c
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Gated edge counter for a bank of ring oscillators: counts rising edges of the
// selected oscillator over a programmable window and exposes the result bytewise.
module ro_freq_counter
   import ro_freq_counter_pkg::*;
#(
   parameter int unsigned NUM_OSC     = 3,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned GATE_W      = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_OSC-1:0]         osc_in,
   input  logic [1:0]                 osc_sel,
   input  logic [GATE_W-1:0]          gate_len,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [CNT_W-1:0]           count,
   output logic                       overflow,
   input  logic [bsel_w(CNT_W)-1:0]   byte_sel,
   output logic [7:0]                 byte_out
);

   localparam int unsigned NBYTES     = (CNT_W + 7) / 8;
   localparam int unsigned PAD_W      = NBYTES * 8;
   localparam int unsigned BSEL_W     = bsel_w(CNT_W);
   localparam int unsigned SETTLE_LEN = settle_len(SYNC_STAGES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state_q, state_nxt;
   logic [1:0]         sel_q;
   logic [GATE_W-1:0]  gate_q;
   logic [GATE_W-1:0]  phase_cnt;
   logic [CNT_W-1:0]   edge_cnt;
   logic               ovf_q;

   logic [NUM_OSC-1:0] rise_vec;
   logic               rise_sel;
   logic               accept;
   logic               settle_last;
   logic               gate_last;
   logic [CNT_W-1:0]   edge_nxt;
   logic               ovf_nxt;
   logic [PAD_W-1:0]   count_pad;

   for (genvar g = 0; g < NUM_OSC; g++) begin : g_sync
      ro_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
         .clk    (clk),
         .rst_n  (rst_n),
         .d      (osc_in[g]),
         .rise_c (rise_vec[g])
      );
   end

   // Out-of-range selects fall through to a constant 0.
   always_comb begin
      rise_sel = 1'b0;
      for (int i = 0; i < NUM_OSC; i++) begin
         if (sel_q == 2'(i)) rise_sel = rise_vec[i];
      end
   end

   always_comb begin
      edge_nxt = edge_cnt;
      ovf_nxt  = ovf_q;
      if (rise_sel) begin
         if (edge_cnt == CNT_MAX) ovf_nxt  = 1'b1;
         else                     edge_nxt = edge_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt   = state_q;
      accept      = 1'b0;
      settle_last = 1'b0;
      gate_last   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (phase_cnt == GATE_W'(SETTLE_LEN - 1)) begin
               settle_last = 1'b1;
               state_nxt   = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (phase_cnt == gate_q - GATE_W'(1)) begin
               gate_last = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs; the result is loaded on the last gate
   // cycle so done and count appear together in the DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= '0;
         gate_q    <= '0;
         phase_cnt <= '0;
         edge_cnt  <= '0;
         ovf_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         count     <= '0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  sel_q     <= osc_sel;
                  gate_q    <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                  phase_cnt <= '0;
                  edge_cnt  <= '0;
                  ovf_q     <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            ST_SETTLE: begin
               phase_cnt <= settle_last ? '0 : phase_cnt + GATE_W'(1);
            end
            ST_COUNT: begin
               phase_cnt <= phase_cnt + GATE_W'(1);
               edge_cnt  <= edge_nxt;
               ovf_q     <= ovf_nxt;
               if (gate_last) begin
                  count    <= edge_nxt;
                  overflow <= ovf_nxt;
                  done     <= 1'b1;
               end
            end
            ST_DONE: busy <= 1'b0;
            default: ;
         endcase
      end
   end

   assign count_pad = PAD_W'(count);

   always_comb begin
      byte_out = 8'h00;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (byte_sel == BSEL_W'(i)) byte_out = count_pad[i*8 +: 8];
      end
   end

endmodule
